// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, serviced from
// a word-addressed RAM after WAIT_STATES wait cycles, with a registered response.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [3:0]  REQ_BE,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = DEPTH_WORDS * 4;
    localparam logic [3:0]  WS_LOAD    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_wait_cnt;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_be;
    logic           r_rsp_valid;
    logic [31:0]    r_rsp_rdata;
    logic           r_rsp_err;
    logic           w_accept;
    logic           w_enter_resp;
    logic           w_leave_resp;
    logic           w_acc_we;
    logic [31:0]    w_acc_addr;
    logic [31:0]    w_acc_wdata;
    logic [3:0]     w_acc_be;
    logic           w_acc_err;
    logic [AW-1:0]  w_acc_idx;
    logic [31:0]    r_mem [DEPTH_WORDS];

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        w_leave_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_next = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_wait_cnt <= 4'd1) begin
                    w_state_next = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    w_state_next = S_IDLE;
                    w_leave_resp = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wait_cnt <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
        end else if (w_accept) begin
            r_wait_cnt <= WS_LOAD;
            r_we       <= REQ_WE;
            r_addr     <= REQ_ADDR;
            r_wdata    <= REQ_WDATA;
            r_be       <= REQ_BE;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // With zero wait states the access happens on the accepting edge, straight from the inputs.
    assign w_acc_we    = (r_state == S_IDLE) ? REQ_WE    : r_we;
    assign w_acc_addr  = (r_state == S_IDLE) ? REQ_ADDR  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? REQ_WDATA : r_wdata;
    assign w_acc_be    = (r_state == S_IDLE) ? REQ_BE    : r_be;
    assign w_acc_err   = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr >= ADDR_LIMIT);
    assign w_acc_idx   = w_acc_addr[AW+1:2];

    // NOTE: the RAM array has no reset; clearing it would defeat RAM inference and is not needed.
    always_ff @(posedge CLK) begin
        if (!RESET && w_enter_resp && w_acc_we && !w_acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (w_acc_err || w_acc_we) ? 32'd0 : r_mem[w_acc_idx];
            r_rsp_err   <= w_acc_err;
        end else if (w_leave_resp) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign REQ_READY = (r_state == S_IDLE);
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_STATES=2 instance for functional,
// error, backpressure and reset cases, plus a WAIT_STATES=0 instance for throughput.
module tb_dmem_responder;

    localparam int unsigned DEPTH  = 1024;
    localparam int          WS_A   = 2;
    localparam logic [31:0] LIMIT  = DEPTH * 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b1;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_be = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) u_dut (
        .CLK(clk), .RESET(reset),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_BE(req_be),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .CLK(clk), .RESET(reset),
        .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready), .REQ_WE(b_req_we),
        .REQ_ADDR(b_req_addr), .REQ_WDATA(b_req_wdata), .REQ_BE(b_req_be),
        .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready),
        .RSP_RDATA(b_rsp_rdata), .RSP_ERR(b_rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: computes the expected response and updates the bench RAM copy.
    task automatic model_req(input bit sel_b, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be, input int acc);
        exp_t        e;
        logic [31:0] w;
        int          idx;
        e.err   = (addr[1:0] != 2'b00) || (addr >= LIMIT);
        e.rdata = 32'd0;
        e.acc   = acc;
        idx     = int'(addr >> 2);
        if (!e.err) begin
            if (sel_b) w = mdl_b.exists(idx) ? mdl_b[idx] : 32'd0;
            else       w = mdl_a.exists(idx) ? mdl_a[idx] : 32'd0;
            if (we) begin
                for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
                if (sel_b) mdl_b[idx] = w;
                else       mdl_a[idx] = w;
            end else begin
                e.rdata = w;
            end
        end
        if (sel_b) q_b.push_back(e);
        else       q_a.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (q_a.size() == 0) begin
                check("a_spurious_rsp", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_rdata", rsp_rdata, e.rdata);
                check("a_err", 32'(rsp_err), 32'(e.err));
            end
        end
        if (!reset && b_rsp_valid && b_rsp_ready) begin
            if (q_b.size() == 0) begin
                check("b_spurious_rsp", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_rdata", b_rsp_rdata, e.rdata);
                check("b_err", 32'(b_rsp_err), 32'(e.err));
                check("b_latency", 32'(cyc + 1 - e.acc), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the WAIT_STATES=2 instance; starts and ends just after a rising edge.
    task automatic do_req_a(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        int n;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("a_req_ready", 32'(req_ready), 32'd1);
        model_req(1'b0, we, addr, wdata, be, 0);
        tick();
        req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
        check("a_rsp_latency", 32'(n), 32'(WS_A + 1));
        n = 0;
        while (!(rsp_valid && rsp_ready) && n < 40) begin @(negedge clk); n++; end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n;
        int          acc;
        int          last_acc;
        logic [31:0] hold_rdata;
        logic        b_we   [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        logic [31:0] b_addr [8] = '{32'h0, 32'h4, 32'h8, 32'h4, 32'h0, 32'h8, 32'h6, 32'h1000};
        logic [31:0] b_data [8] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 0, 0, 0, 0, 0};

        repeat (3) tick();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        do_req_a(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        do_req_a(1'b0, 32'h10, 32'h0, 4'b0000);
        do_req_a(1'b1, 32'h20, 32'h11223344, 4'b1111);
        do_req_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_req_a(1'b0, 32'h20, 32'h0, 4'b1111);
        do_req_a(1'b1, 32'h20, 32'h99999999, 4'b0000);
        do_req_a(1'b0, 32'h20, 32'h0, 4'b0000);
        do_req_a(1'b0, 32'h22, 32'h0, 4'b0000);
        do_req_a(1'b1, 32'h0, 32'h12345678, 4'b1111);
        do_req_a(1'b1, LIMIT, 32'hFFFFFFFF, 4'b1111);
        do_req_a(1'b0, 32'h0, 32'h0, 4'b0000);
        do_req_a(1'b1, LIMIT - 4, 32'h0BADF00D, 4'b1111);
        do_req_a(1'b0, LIMIT - 4, 32'h0, 4'b0000);

        // Backpressure: response held five cycles while a stray request pulse is ignored.
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; req_be = 4'b0000;
        @(negedge clk);
        model_req(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 0);
        hold_rdata = q_a[0].rdata;
        tick();
        req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, hold_rdata);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
            if (i == 1) begin
                req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'b1111;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
        end
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_after_req_ready", 32'(req_ready), 32'd1);
        check("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        do_req_a(1'b0, 32'h10, 32'h0, 4'b0000);

        // Reset one cycle after accepting a store: the store must be abandoned.
        do_req_a(1'b1, 32'h40, 32'h0, 4'b1111);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_be = 4'b1111;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rstw_req_ready", 32'(req_ready), 32'd1);
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tick();
        do_req_a(1'b0, 32'h40, 32'h0, 4'b0000);

        // Zero wait states: REQ_VALID held high, new accept every two cycles.
        last_acc = 0;
        for (int k = 0; k < 8; k++) begin
            b_req_we = b_we[k]; b_req_addr = b_addr[k]; b_req_wdata = b_data[k];
            b_req_be = 4'b1111; b_req_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!b_req_ready && n < 10) begin @(negedge clk); n++; end
            check("b_req_ready", 32'(b_req_ready), 32'd1);
            acc = cyc + 1;
            if (k > 0) check("b_spacing", 32'(acc - last_acc), 32'd2);
            last_acc = acc;
            model_req(1'b1, b_we[k], b_addr[k], b_data[k], 4'b1111, acc);
            tick();
        end
        b_req_valid = 1'b0;
        repeat (4) tick();

        check("a_queue_empty", 32'(q_a.size()), 32'd0);
        check("b_queue_empty", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
